mem_align_unit: RTL and testbench
=================================

Name: mem_align_unit

Overview:
Parametrised load/store alignment engine between the MEM stage and the data-cache port. Generates byte enables from funct3 and address, lane-shifts store data and extracts/extends load data. Unlike a single-cycle mask generator, it splits line-word-crossing (misaligned) accesses into two sequential bus transactions and merges the results. Optionally raises a fault instead of splitting.

Parameters:
XLEN, 32, data/bus width in bits (32 or 64); BYTES = XLEN/8, OFFW = log2(BYTES)
ALLOW_MISALIGNED, 1, 1 = split misaligned accesses; 0 = fault without any memory access

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  1  MEM-stage request present
req_ready  out  1  unit can accept a request (IDLE)
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV funct3 (size in [1:0], unsigned in [2])
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data, LSB-aligned
mem_read  out  1  cache read strobe
mem_write  out  1  cache write strobe
mem_address  out  XLEN  BYTES-aligned address (low OFFW bits zero)
mem_byte_enable  out  BYTES  byte lanes
mem_wdata  out  XLEN  lane-shifted store data
mem_resp  in  1  cache completes the current access
mem_rdata  in  XLEN  cache read data
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  extended load result (0 for stores)
resp_fault  out  1  misaligned with ALLOW_MISALIGNED=0, or illegal funct3

Behaviour:
- Reset: all outputs 0 except req_ready=1; state IDLE; merge buffer cleared. Reset mid-access abandons the transaction immediately (strobes drop asynchronously).
- size = 1<<funct3[1:0]; off = addr[OFFW-1:0]. Legal funct3: 000,001,010,100,101; for XLEN=64 also 011,110. Others are illegal.
- Misaligned = off+size > BYTES. Bytes below BYTES form part 0, the rest part 1.
- FSM states: IDLE, ACC0, ACC1, DONE. All outputs are registered.
- IDLE: req_ready=1; on req_valid the request and address are latched. Illegal, or misaligned with ALLOW_MISALIGNED=0 -> DONE with fault. Otherwise -> ACC0.
- ACC0: mem_address = {addr[XLEN-1:OFFW], 0}; byte_enable = (ones(size) << off) truncated to BYTES; wdata = req_wdata << 8*off. Strobe is held until mem_resp. On mem_resp: load bytes are captured into the merge buffer, then -> ACC1 if misaligned, else DONE.
- ACC1: mem_address = part-0 address + BYTES, wrapping at 2^XLEN; byte_enable = ones(size) >> (BYTES-off); wdata = req_wdata >> 8*(BYTES-off). On mem_resp: bytes merged, then -> DONE.
- DONE: resp_valid=1 for exactly one cycle, then -> IDLE. Same-cycle re-accept is not allowed, so req_ready=0.
- Load extension: sign-extend from bit 8*size-1 when funct3[2]=0, zero-extend otherwise.
- Strobes are never asserted in IDLE or DONE. mem_read and mem_write are never both 1.
- Minimum latency, aligned with mem_resp the first cycle it can arrive: accept at edge T, strobe in T+1, resp_valid in T+2. Split access adds at least one cycle.

Decomposition:
- Shared package rv32i_types gains: load/store funct3 enum (lb, lh, lw, ld, lbu, lhu, lwu / sb, sh, sw, sd), mem_align_state_t enum, and an XLEN-generic byte-enable type.
- One sub-module, mem_lane_shift: combinational shifter/extender. Inputs are data, off, size, dir and unsigned; output is the shifted or extended word. It is instantiated once for the store path and once for the load path.

Test Plan:
- LW at 0x1000_0004, mem_rdata 0xDEADBEEF, mem_resp in first cycle -> one read, address 0x1000_0004, be 1111, resp_rdata 0xDEADBEEF, resp_valid 2 cycles after accept.
- LB at 0x0000_0103, rdata 0x80FF_FFFF -> be 1000, resp 0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- SW 0x1122_3344 at 0x2002 -> access 0: address 0x2000, be 1100, wdata[31:16]=0x3344. Access 1: address 0x2004, be 0011, wdata[15:0]=0x1122. resp_valid only after the second mem_resp.
- LH at 0x3003, word 0 = 0xAB00_0000, word 1 = 0x0000_00CD -> be 1000 then 0001, resp 0xFFFF_CDAB. Also exercise mem_resp delayed 3 cycles with strobe held.
- ALLOW_MISALIGNED=0, LW at 0x4001 -> no strobe ever, resp_valid with resp_fault=1 one cycle after accept. funct3=111 behaves the same in both modes.
- rst driven low during ACC1 -> strobes drop immediately, no resp_valid. After release, req_ready=1 and a new LW completes normally. With XLEN=64, an SD at offset 4 splits into be 0xF0 then 0x0F.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32/RV64 types for the MEM stage.
// funct3 encodings, align FSM state, byte-enable type.
package rv32i_types;

   localparam int MAX_BYTES = 8;

   typedef logic [MAX_BYTES-1:0] byte_en_t;

   typedef enum logic [2:0] {
      lb  = 3'b000,
      lh  = 3'b001,
      lw  = 3'b010,
      ld  = 3'b011,
      lbu = 3'b100,
      lhu = 3'b101,
      lwu = 3'b110
   } load_funct3_t;

   typedef enum logic [2:0] {
      sb = 3'b000,
      sh = 3'b001,
      sw = 3'b010,
      sd = 3'b011
   } store_funct3_t;

   typedef enum logic [1:0] {
      IDLE,
      ACC0,
      ACC1,
      DONE
   } mem_align_state_t;

   function automatic logic funct3_legal(
      input logic [2:0] f3,
      input int         xlen
   );
      case (f3)
         lb, lh, lw, lbu, lhu: return 1'b1;
         ld, lwu:              return xlen == 64;
         default:              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lane_shift.sv
// Byte-lane shifter and load extender.
// data/off/size/dir/uns in; result = shifted word, extended above 8<<size bits.
module mem_lane_shift #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]            data,
   input  logic [$clog2(XLEN/8)-1:0]  off,
   input  logic [1:0]                 size,
   input  logic                       dir,
   input  logic                       uns,
   output logic [XLEN-1:0]            result
);

   logic [XLEN-1:0] sh;
   int              nbits;
   logic            sign;

   always_comb begin
      sh = dir ? data >> {off, 3'b000}
               : data << {off, 3'b000};
      nbits = 8 << size;
      sign = 1'b0;
      for (int i = 0; i < XLEN; i++)
         if (!uns && i == nbits - 1)
            sign = sh[i];
      result = sh;
      // A full-width size leaves the word untouched.
      for (int i = 0; i < XLEN; i++)
         if (i >= nbits)
            result[i] = sign;
   end

endmodule

// File: rtl/mem_align_unit.sv
// Load/store alignment engine: byte enables, lane shift, split of misaligned accesses.
// req_* from MEM stage, mem_* to data cache, resp_* back as a one-cycle pulse.
module mem_align_unit
   import rv32i_types::*;
#(
   parameter int XLEN             = 32,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [XLEN-1:0]   mem_address,
   output logic [XLEN/8-1:0] mem_byte_enable,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_resp,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_fault
);

   localparam int         BYTES = XLEN / 8;
   localparam int         OFFW  = $clog2(BYTES);
   localparam int         MW    = 2 * BYTES;
   localparam logic [1:0] FULL  = 2'(OFFW);

   mem_align_state_t state;
   logic             r_write;
   logic             r_mis;
   logic [2:0]       r_f3;
   logic [OFFW-1:0]  r_off;
   logic [XLEN-1:0]  r_wdata;
   logic [XLEN-1:0]  mbuf;

   logic             idle;
   logic [2:0]       f3_sel;
   logic [OFFW-1:0]  req_off;
   logic [OFFW-1:0]  off_sel;
   logic [OFFW-1:0]  neg_off;
   byte_en_t         ones_w;
   logic [MW-1:0]    mask2;
   logic             mis_sel;
   logic             bad;
   logic [XLEN-1:0]  merged;
   logic [XLEN-1:0]  st_out;
   logic [XLEN-1:0]  ld_out;

   assign idle    = state == IDLE;
   assign req_off = req_addr[OFFW-1:0];
   assign f3_sel  = idle ? req_funct3 : r_f3;
   assign off_sel = idle ? req_off : r_off;
   // BYTES - off, valid because a split never has off == 0.
   assign neg_off = -r_off;

   always_comb begin
      ones_w = '0;
      for (int i = 0; i < MAX_BYTES; i++)
         ones_w[i] = i < (1 << f3_sel[1:0]);
   end

   // Low half = part-0 lanes, high half = part-1 lanes.
   assign mask2   = MW'(ones_w) << off_sel;
   assign mis_sel = |mask2[MW-1:BYTES];
   assign bad     = !funct3_legal(req_funct3, XLEN)
                 || (mis_sel && !ALLOW_MISALIGNED);

   always_comb begin
      if (state == ACC1)
         merged = mbuf | (mem_rdata << {neg_off, 3'b000});
      else
         merged = mem_rdata >> {r_off, 3'b000};
   end

   // IDLE: shift left for part 0; otherwise shift right for part 1.
   mem_lane_shift #(.XLEN(XLEN)) u_st_shift (
      .data   (idle ? req_wdata : r_wdata),
      .off    (idle ? req_off : neg_off),
      .size   (FULL),
      .dir    (!idle),
      .uns    (1'b1),
      .result (st_out)
   );

   mem_lane_shift #(.XLEN(XLEN)) u_ld_shift (
      .data   (merged),
      .off    ('0),
      .size   (r_f3[1:0]),
      .dir    (1'b1),
      .uns    (r_f3[2]),
      .result (ld_out)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         req_ready       <= 1'b1;
         mem_read        <= 1'b0;
         mem_write       <= 1'b0;
         mem_address     <= '0;
         mem_byte_enable <= '0;
         mem_wdata       <= '0;
         resp_valid      <= 1'b0;
         resp_rdata      <= '0;
         resp_fault      <= 1'b0;
         r_write         <= 1'b0;
         r_mis           <= 1'b0;
         r_f3            <= '0;
         r_off           <= '0;
         r_wdata         <= '0;
         mbuf            <= '0;
      end else begin
         unique case (state)
            IDLE: if (req_valid) begin
               req_ready <= 1'b0;
               r_write   <= req_write;
               r_f3      <= req_funct3;
               r_off     <= req_off;
               r_wdata   <= req_wdata;
               r_mis     <= mis_sel;
               mbuf      <= '0;
               if (bad) begin
                  state      <= DONE;
                  resp_valid <= 1'b1;
                  resp_fault <= 1'b1;
                  resp_rdata <= '0;
               end else begin
                  state           <= ACC0;
                  mem_read        <= !req_write;
                  mem_write       <= req_write;
                  mem_address     <= {req_addr[XLEN-1:OFFW],
                                      {OFFW{1'b0}}};
                  mem_byte_enable <= mask2[BYTES-1:0];
                  mem_wdata       <= st_out;
               end
            end
            ACC0, ACC1: if (mem_resp) begin
               mbuf <= merged;
               if (state == ACC0 && r_mis) begin
                  state           <= ACC1;
                  mem_address     <= mem_address + XLEN'(BYTES);
                  mem_byte_enable <= mask2[MW-1:BYTES];
                  mem_wdata       <= st_out;
               end else begin
                  state           <= DONE;
                  mem_read        <= 1'b0;
                  mem_write       <= 1'b0;
                  mem_byte_enable <= '0;
                  resp_valid      <= 1'b1;
                  resp_fault      <= 1'b0;
                  resp_rdata      <= r_write ? '0 : ld_out;
               end
            end
            DONE: begin
               state      <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_fault <= 1'b0;
               resp_rdata <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed bench for mem_align_unit.
// Three instances: 32-bit split, 32-bit fault-only, 64-bit split.
module tb_mem_align_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        mem_resp;
   logic [31:0] mem_rdata;

   logic        a_valid, a_ready, a_rd, a_wr, a_rv, a_fault;
   logic [31:0] a_addr, a_wd, a_rdata;
   logic [3:0]  a_be;

   logic        b_valid, b_ready, b_rd, b_wr, b_rv, b_fault;
   logic [31:0] b_addr, b_wd, b_rdata;
   logic [3:0]  b_be;

   logic        c_valid, c_ready, c_write, c_resp;
   logic        c_rd, c_wr, c_rv, c_fault;
   logic [2:0]  c_f3;
   logic [63:0] c_req_addr, c_req_wdata, c_mem_rdata;
   logic [63:0] c_addr, c_wd, c_rdata;
   logic [7:0]  c_be;

   mem_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) u_a (
      .clk(clk), .rst(rst),
      .req_valid(a_valid), .req_ready(a_ready),
      .req_write(req_write), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_read(a_rd), .mem_write(a_wr),
      .mem_address(a_addr), .mem_byte_enable(a_be),
      .mem_wdata(a_wd), .mem_resp(mem_resp),
      .mem_rdata(mem_rdata), .resp_valid(a_rv),
      .resp_rdata(a_rdata), .resp_fault(a_fault)
   );

   mem_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) u_b (
      .clk(clk), .rst(rst),
      .req_valid(b_valid), .req_ready(b_ready),
      .req_write(req_write), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_read(b_rd), .mem_write(b_wr),
      .mem_address(b_addr), .mem_byte_enable(b_be),
      .mem_wdata(b_wd), .mem_resp(mem_resp),
      .mem_rdata(mem_rdata), .resp_valid(b_rv),
      .resp_rdata(b_rdata), .resp_fault(b_fault)
   );

   mem_align_unit #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) u_c (
      .clk(clk), .rst(rst),
      .req_valid(c_valid), .req_ready(c_ready),
      .req_write(c_write), .req_funct3(c_f3),
      .req_addr(c_req_addr), .req_wdata(c_req_wdata),
      .mem_read(c_rd), .mem_write(c_wr),
      .mem_address(c_addr), .mem_byte_enable(c_be),
      .mem_wdata(c_wd), .mem_resp(c_resp),
      .mem_rdata(c_mem_rdata), .resp_valid(c_rv),
      .resp_rdata(c_rdata), .resp_fault(c_fault)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_load(input logic [2:0]  f3,
                         input logic [31:0] addr,
                         input logic [31:0] rdata,
                         input logic [3:0]  be,
                         input logic [31:0] res);
      req_write  = 1'b0;
      req_funct3 = f3;
      req_addr   = addr;
      mem_rdata  = rdata;
      mem_resp   = 1'b1;
      a_valid    = 1'b1;
      step();
      a_valid = 1'b0;
      chk("ld_rd", a_rd, 1'b1);
      chk("ld_addr", a_addr, addr & 32'hFFFF_FFFC);
      chk("ld_be", a_be, be);
      step();
      chk("ld_rv", a_rv, 1'b1);
      chk("ld_data", a_rdata, res);
      chk("ld_fault", a_fault, 1'b0);
      mem_resp = 1'b0;
      step();
      chk("ld_ready", a_ready, 1'b1);
   endtask

   initial begin
      rst = 1'b0;
      req_write = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0;
      mem_resp = 1'b0; mem_rdata = '0;
      a_valid = 1'b0; b_valid = 1'b0;
      c_valid = 1'b0; c_write = 1'b0; c_f3 = '0;
      c_resp = 1'b0; c_req_addr = '0;
      c_req_wdata = '0; c_mem_rdata = '0;
      repeat (2) step();
      chk("rst_ready", a_ready, 1'b1);
      chk("rst_rd", a_rd, 1'b0);
      chk("rst_rv", a_rv, 1'b0);
      chk("rst_be", a_be, 4'h0);
      rst = 1'b1;
      step();

      // Aligned LW, resp in the first strobe cycle.
      req_write  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h1000_0004;
      mem_rdata  = 32'hDEAD_BEEF;
      mem_resp   = 1'b1;
      a_valid    = 1'b1;
      chk("lw_ready", a_ready, 1'b1);
      step();
      a_valid = 1'b0;
      chk("lw_rd", a_rd, 1'b1);
      chk("lw_wr", a_wr, 1'b0);
      chk("lw_addr", a_addr, 32'h1000_0004);
      chk("lw_be", a_be, 4'hF);
      chk("lw_rv0", a_rv, 1'b0);
      step();
      chk("lw_rv", a_rv, 1'b1);
      chk("lw_data", a_rdata, 32'hDEAD_BEEF);
      chk("lw_rd_off", a_rd, 1'b0);
      chk("lw_busy", a_ready, 1'b0);
      mem_resp = 1'b0;
      step();
      chk("lw_pulse", a_rv, 1'b0);
      chk("lw_idle", a_ready, 1'b1);

      // LB / LBU on the top lane.
      a_load(3'b000, 32'h0000_0103, 32'h80FF_FFFF,
             4'b1000, 32'hFFFF_FF80);
      a_load(3'b100, 32'h0000_0103, 32'h80FF_FFFF,
             4'b1000, 32'h0000_0080);

      // Split SW at 0x2002.
      req_write  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_2002;
      req_wdata  = 32'h1122_3344;
      mem_resp   = 1'b1;
      a_valid    = 1'b1;
      step();
      a_valid = 1'b0;
      chk("sw0_wr", a_wr, 1'b1);
      chk("sw0_rd", a_rd, 1'b0);
      chk("sw0_addr", a_addr, 32'h0000_2000);
      chk("sw0_be", a_be, 4'b1100);
      chk("sw0_wd", a_wd[31:16], 16'h3344);
      step();
      chk("sw1_wr", a_wr, 1'b1);
      chk("sw1_addr", a_addr, 32'h0000_2004);
      chk("sw1_be", a_be, 4'b0011);
      chk("sw1_wd", a_wd[15:0], 16'h1122);
      chk("sw1_rv", a_rv, 1'b0);
      step();
      chk("sw_rv", a_rv, 1'b1);
      chk("sw_rdata", a_rdata, 32'h0);
      chk("sw_wr_off", a_wr, 1'b0);
      mem_resp = 1'b0;
      step();

      // Split LH at 0x3003 with a 3-cycle late response.
      req_write  = 1'b0;
      req_funct3 = 3'b001;
      req_addr   = 32'h0000_3003;
      a_valid    = 1'b1;
      step();
      a_valid = 1'b0;
      chk("lh0_addr", a_addr, 32'h0000_3000);
      chk("lh0_be", a_be, 4'b1000);
      repeat (2) begin
         step();
         chk("lh_hold", a_rd, 1'b1);
      end
      mem_resp  = 1'b1;
      mem_rdata = 32'hAB00_0000;
      step();
      chk("lh1_addr", a_addr, 32'h0000_3004);
      chk("lh1_be", a_be, 4'b0001);
      chk("lh1_rd", a_rd, 1'b1);
      mem_rdata = 32'h0000_00CD;
      step();
      chk("lh_rv", a_rv, 1'b1);
      chk("lh_data", a_rdata, 32'hFFFF_CDAB);
      mem_resp = 1'b0;
      step();

      // Split LW across the top of the address space.
      req_funct3 = 3'b010;
      req_addr   = 32'hFFFF_FFFE;
      mem_rdata  = 32'h5566_7788;
      mem_resp   = 1'b1;
      a_valid    = 1'b1;
      step();
      a_valid = 1'b0;
      chk("wr0_addr", a_addr, 32'hFFFF_FFFC);
      chk("wr0_be", a_be, 4'b1100);
      step();
      chk("wr1_addr", a_addr, 32'h0);
      chk("wr1_be", a_be, 4'b0011);
      step();
      chk("wr_data", a_rdata, 32'h7788_5566);
      mem_resp = 1'b0;
      step();

      // Fault-only instance: misaligned LW.
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_4001;
      b_valid    = 1'b1;
      step();
      b_valid = 1'b0;
      chk("mis_rd", b_rd, 1'b0);
      chk("mis_wr", b_wr, 1'b0);
      chk("mis_rv", b_rv, 1'b1);
      chk("mis_fault", b_fault, 1'b1);
      step();
      chk("mis_pulse", b_rv, 1'b0);
      chk("mis_ready", b_ready, 1'b1);

      // Illegal funct3 on both instances.
      req_funct3 = 3'b111;
      req_addr   = 32'h0000_4000;
      a_valid    = 1'b1;
      b_valid    = 1'b1;
      step();
      a_valid = 1'b0;
      b_valid = 1'b0;
      chk("ill_a_rd", a_rd, 1'b0);
      chk("ill_a_fault", a_fault, 1'b1);
      chk("ill_a_rv", a_rv, 1'b1);
      chk("ill_b_fault", b_fault, 1'b1);
      step();

      // Reset while in the second access.
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_5002;
      mem_resp   = 1'b1;
      a_valid    = 1'b1;
      step();
      a_valid = 1'b0;
      step();
      chk("rs_acc1_rd", a_rd, 1'b1);
      chk("rs_acc1_addr", a_addr, 32'h0000_5004);
      mem_resp = 1'b0;
      rst = 1'b0;
      #1;
      chk("rs_rd_drop", a_rd, 1'b0);
      chk("rs_be_drop", a_be, 4'h0);
      step();
      chk("rs_rv", a_rv, 1'b0);
      chk("rs_ready", a_ready, 1'b1);
      rst = 1'b1;
      step();
      a_load(3'b010, 32'h0000_0010, 32'h1234_5678,
             4'hF, 32'h1234_5678);

      // 64-bit SD at offset 4.
      c_write     = 1'b1;
      c_f3        = 3'b011;
      c_req_addr  = 64'h8004;
      c_req_wdata = 64'h0102_0304_0506_0708;
      c_resp      = 1'b1;
      c_valid     = 1'b1;
      step();
      c_valid = 1'b0;
      chk("sd0_wr", c_wr, 1'b1);
      chk("sd0_addr", c_addr, 64'h8000);
      chk("sd0_be", c_be, 8'hF0);
      chk("sd0_wd", c_wd, 64'h0506_0708_0000_0000);
      step();
      chk("sd1_addr", c_addr, 64'h8008);
      chk("sd1_be", c_be, 8'h0F);
      chk("sd1_wd", c_wd, 64'h0000_0000_0102_0304);
      step();
      chk("sd_rv", c_rv, 1'b1);
      step();

      // 64-bit LW in the upper half, sign-extended.
      c_write     = 1'b0;
      c_f3        = 3'b010;
      c_mem_rdata = 64'h8000_0000_0000_0000;
      c_valid     = 1'b1;
      step();
      c_valid = 1'b0;
      chk("lw64_be", c_be, 8'hF0);
      step();
      chk("lw64_rv", c_rv, 1'b1);
      chk("lw64_data", c_rdata, 64'hFFFF_FFFF_8000_0000);
      c_resp = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
